// File: rtl/qracc_pkg.sv
// Shared types and widths for the window fetch sequencer.
//   addrWidth : buffer / feature-loader address width
//   dimWidth  : width of the H/W/C configuration fields
//   maxK      : largest supported filter size; kWidth is derived from it
//   wfs_state_t : sequencer FSM states
//   wfs_cfg_t   : layer configuration latched on start
package qracc_pkg;

    localparam int unsigned addrWidth = 32;
    localparam int unsigned dimWidth  = 8;
    localparam int unsigned maxK      = 3;
    localparam int unsigned kWidth    = $clog2(maxK + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        WAIT,
        DONE
    } wfs_state_t;

    typedef struct packed {
        logic [dimWidth-1:0]  in_h;
        logic [dimWidth-1:0]  in_w;
        logic [dimWidth-1:0]  num_ch;
        logic [kWidth-1:0]    k;
        logic [1:0]           stride;
        logic [1:0]           pad;
        logic [addrWidth-1:0] base;
        logic [addrWidth-1:0] pix_step;
    } wfs_cfg_t;

endpackage

// File: rtl/win_addr_calc.sv
// Combinational address generator for one slot of a convolution window.
// Inputs : cfg (latched layer config), oy/ox (output pixel), ky/kx (slot in window)
// Outputs: rd_addr (buffer line address; base when the slot falls in the pad border),
//          oob (slot lies outside the input image), fl_addr (feature-loader element offset)
module win_addr_calc
    import qracc_pkg::*;
(
    input  wfs_cfg_t             cfg,
    input  logic [dimWidth-1:0]  oy,
    input  logic [dimWidth-1:0]  ox,
    input  logic [kWidth-1:0]    ky,
    input  logic [kWidth-1:0]    kx,
    output logic [addrWidth-1:0] rd_addr,
    output logic                 oob,
    output logic [addrWidth-1:0] fl_addr
);

    // Two extra bits: one for the sign of the padded coordinate, one for stride growth.
    localparam int unsigned SW = dimWidth + 2;

    logic signed [SW-1:0]  iy;
    logic signed [SW-1:0]  ix;
    logic [addrWidth-1:0]  lin;

    always_comb begin
        iy  = $signed(SW'(oy) * SW'(cfg.stride) + SW'(ky) - SW'(cfg.pad));
        ix  = $signed(SW'(ox) * SW'(cfg.stride) + SW'(kx) - SW'(cfg.pad));
        oob = iy[SW-1] || ix[SW-1] ||
              (iy >= $signed(SW'(cfg.in_h))) || (ix >= $signed(SW'(cfg.in_w)));
        // Only meaningful when in bounds; both coordinates are then non-negative.
        lin = addrWidth'($unsigned(iy)) * addrWidth'(cfg.in_w) + addrWidth'($unsigned(ix));
        rd_addr = oob ? cfg.base : cfg.base + lin * cfg.pix_step;
        fl_addr = (addrWidth'(ky) * addrWidth'(cfg.k) + addrWidth'(kx)) *
                  addrWidth'(cfg.num_ch);
    end

endmodule

// File: rtl/window_fetch_sequencer.sv
// Walks the KxK window of each conv output pixel: one activation-buffer read per cycle,
// with padder range and feature-loader write address aligned to the returning data, then
// presents the staged window to the consumer through win_valid_o / win_ready_i.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start_i, cfg_*_i   start pulse and layer configuration (latched in IDLE only)
//   abuf_rd_en_o/addr  buffer internal read
//   pad_start_o/end_o  padder range for the data returning this cycle
//   fl_wr_en_o/addr_o  feature-loader write for the data returning this cycle
//   win_valid_o/ready  window handshake; oy_o/ox_o give its output coordinates
//   busy_o, done_o     not idle / one-cycle end-of-layer pulse
//   cfg_err_o          sticky invalid-config flag, cleared by the next start
module window_fetch_sequencer
    import qracc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [dimWidth-1:0]  cfg_in_h_i,
    input  logic [dimWidth-1:0]  cfg_in_w_i,
    input  logic [dimWidth-1:0]  cfg_num_ch_i,
    input  logic [kWidth-1:0]    cfg_k_i,
    input  logic [1:0]           cfg_stride_i,
    input  logic [1:0]           cfg_pad_i,
    input  logic [addrWidth-1:0] cfg_base_i,
    input  logic [addrWidth-1:0] cfg_pix_step_i,
    output logic                 abuf_rd_en_o,
    output logic [addrWidth-1:0] abuf_rd_addr_o,
    output logic [dimWidth-1:0]  pad_start_o,
    output logic [dimWidth-1:0]  pad_end_o,
    output logic                 fl_wr_en_o,
    output logic [addrWidth-1:0] fl_addr_o,
    output logic                 win_valid_o,
    input  logic                 win_ready_i,
    output logic [dimWidth-1:0]  oy_o,
    output logic [dimWidth-1:0]  ox_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 cfg_err_o
);

    localparam int unsigned EW = dimWidth + 2;

    wfs_state_t           state_q;
    wfs_cfg_t             cfg_q;
    wfs_cfg_t             cfg_in;
    logic [kWidth-1:0]    ky_q, kx_q;
    logic [dimWidth-1:0]  oy_q, ox_q;
    logic [dimWidth-1:0]  oh_last_q, ow_last_q;
    logic                 win_valid_q, done_q, cfg_err_q;
    logic                 fl_wr_en_q;
    logic [addrWidth-1:0] fl_addr_q;
    logic [dimWidth-1:0]  pad_end_q;

    logic [EW-1:0]        h_ext, w_ext;
    logic                 cfg_bad;
    logic [dimWidth-1:0]  oh_last_d, ow_last_d;
    logic                 rd_en;
    logic                 kx_last, ky_last;
    logic [addrWidth-1:0] calc_rd_addr, calc_fl_addr;
    logic                 calc_oob;

    win_addr_calc u_addr (
        .cfg     (cfg_q),
        .oy      (oy_q),
        .ox      (ox_q),
        .ky      (ky_q),
        .kx      (kx_q),
        .rd_addr (calc_rd_addr),
        .oob     (calc_oob),
        .fl_addr (calc_fl_addr)
    );

    // Config check and output-grid extent, evaluated on the raw inputs at start.
    always_comb begin
        cfg_in = '{in_h: cfg_in_h_i, in_w: cfg_in_w_i, num_ch: cfg_num_ch_i, k: cfg_k_i,
                   stride: cfg_stride_i, pad: cfg_pad_i, base: cfg_base_i,
                   pix_step: cfg_pix_step_i};
        h_ext   = EW'(cfg_in_h_i) + EW'({cfg_pad_i, 1'b0});
        w_ext   = EW'(cfg_in_w_i) + EW'({cfg_pad_i, 1'b0});
        cfg_bad = (cfg_k_i == '0) || (cfg_stride_i == '0) || (cfg_num_ch_i == '0) ||
                  (EW'(cfg_k_i) > h_ext) || (EW'(cfg_k_i) > w_ext);
        oh_last_d = '0;
        ow_last_d = '0;
        if (!cfg_bad) begin
            oh_last_d = dimWidth'((h_ext - EW'(cfg_k_i)) / EW'(cfg_stride_i));
            ow_last_d = dimWidth'((w_ext - EW'(cfg_k_i)) / EW'(cfg_stride_i));
        end
    end

    assign rd_en   = (state_q == FETCH);
    assign kx_last = (kx_q == cfg_q.k - kWidth'(1));
    assign ky_last = (ky_q == cfg_q.k - kWidth'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cfg_q       <= '0;
            ky_q        <= '0;
            kx_q        <= '0;
            oy_q        <= '0;
            ox_q        <= '0;
            oh_last_q   <= '0;
            ow_last_q   <= '0;
            win_valid_q <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            fl_wr_en_q  <= 1'b0;
            fl_addr_q   <= '0;
            pad_end_q   <= '0;
        end else begin
            done_q     <= 1'b0;
            // Buffer read latency is one cycle: padder and feature-loader controls
            // follow the read by one stage so they line up with the returning line.
            fl_wr_en_q <= rd_en;
            fl_addr_q  <= rd_en ? calc_fl_addr : '0;
            pad_end_q  <= (rd_en && calc_oob) ? cfg_q.num_ch : '0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        cfg_q     <= cfg_in;
                        cfg_err_q <= cfg_bad;
                        oh_last_q <= oh_last_d;
                        ow_last_q <= ow_last_d;
                        ky_q      <= '0;
                        kx_q      <= '0;
                        oy_q      <= '0;
                        ox_q      <= '0;
                        if (cfg_bad) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (kx_last) begin
                        kx_q <= '0;
                        if (ky_last) begin
                            ky_q    <= '0;
                            state_q <= DRAIN;
                        end else begin
                            ky_q <= ky_q + kWidth'(1);
                        end
                    end else begin
                        kx_q <= kx_q + kWidth'(1);
                    end
                end
                DRAIN: begin
                    state_q     <= WAIT;
                    win_valid_q <= 1'b1;
                end
                WAIT: begin
                    if (win_ready_i) begin
                        win_valid_q <= 1'b0;
                        if (ox_q == ow_last_q) begin
                            ox_q <= '0;
                            if (oy_q == oh_last_q) begin
                                oy_q    <= '0;
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                oy_q    <= oy_q + dimWidth'(1);
                                state_q <= FETCH;
                            end
                        end else begin
                            ox_q    <= ox_q + dimWidth'(1);
                            state_q <= FETCH;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign abuf_rd_en_o   = rd_en;
    assign abuf_rd_addr_o = rd_en ? calc_rd_addr : '0;
    // Padded slots always zero the whole line from element 0.
    assign pad_start_o    = '0;
    assign pad_end_o      = pad_end_q;
    assign fl_wr_en_o     = fl_wr_en_q;
    assign fl_addr_o      = fl_addr_q;
    assign win_valid_o    = win_valid_q;
    assign oy_o           = oy_q;
    assign ox_o           = ox_q;
    assign busy_o         = (state_q != IDLE);
    assign done_o         = done_q;
    assign cfg_err_o      = cfg_err_q;

endmodule
